// File: rtl/mpi_wb_mc.sv
// rtl/mpi_wb_mc.sv - Multi-channel Wishbone message-passing endpoint
// N independent NoC lanes, each with a TX packet FIFO, an RX flit FIFO and a pending-packet counter.
module mpi_wb_mc #(
  parameter int NOC_FLIT_WIDTH = 32,
  parameter int SIZE           = 16,
  parameter int N              = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [N*NOC_FLIT_WIDTH-1:0] noc_out_flit,
  output logic [N-1:0]                noc_out_last,
  output logic [N-1:0]                noc_out_valid,
  input  logic [N-1:0]                noc_out_ready,
  input  logic [N*NOC_FLIT_WIDTH-1:0] noc_in_flit,
  input  logic [N-1:0]                noc_in_last,
  input  logic [N-1:0]                noc_in_valid,
  output logic [N-1:0]                noc_in_ready,
  input  logic [31:0]                 wb_adr_i,
  input  logic                        wb_we_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic [31:0]                 wb_dat_i,
  output logic [31:0]                 wb_dat_o,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic                        irq
);
  localparam int W  = NOC_FLIT_WIDTH;
  localparam int AW = $clog2(SIZE);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, SEND} tx_state_t;

  logic              req, we, ch_ok, err_any, rdy_en;
  logic [7:0]        ch;
  logic [1:0]        rg;
  logic [N-1:0]      ch_err, ch_irq;
  logic [N-1:0][31:0] ch_rdata;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign ch      = wb_adr_i[11:4];
  assign rg      = wb_adr_i[3:2];
  assign we      = wb_we_i;
  assign ch_ok   = {1'b0, ch} < 9'(N);
  assign err_any = req & (~ch_ok | (|ch_err));
  assign unused_bits = ^{wb_adr_i[31:12], wb_adr_i[1:0], wb_dat_i};

  always_comb begin
    rdata = '0;
    for (int k = 0; k < N; k++) rdata = rdata | ch_rdata[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      irq      <= 1'b0;
      rdy_en   <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      wb_ack_o <= req & ~err_any;
      wb_err_o <= err_any;
      wb_dat_o <= (req & ~err_any & ~we) ? rdata : '0;
      irq      <= |ch_irq;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_ch
    tx_state_t       tx_state;
    logic [W-1:0]    tx_mem [SIZE];
    logic [W:0]      rx_mem [SIZE];
    logic [AW-1:0]   tx_wp, tx_rp, rx_wp, rx_rp;
    logic [LW-1:0]   tx_lvl, rx_lvl;
    logic [7:0]      pend;
    logic            ien, sel, cerr, act, busy;
    logic            tx_empty, tx_full, rx_empty, rx_full, head_last;
    logic            tx_push, tx_pop, do_send, rx_push, rx_pop, ien_wr, pend_inc, pend_dec;
    logic [W:0]      rx_head;
    logic [31:0]     rd;

    assign sel       = req & (ch == 8'(k));
    assign busy      = (tx_state == SEND);
    assign tx_empty  = (tx_lvl == '0);
    assign tx_full   = (tx_lvl == LW'(SIZE));
    assign rx_empty  = (rx_lvl == '0);
    assign rx_full   = (rx_lvl == LW'(SIZE));
    assign rx_head   = rx_mem[rx_rp];
    assign head_last = rx_head[W] & ~rx_empty;

    // Errors are resolved before any side effect so a rejected access leaves state untouched.
    assign cerr = sel & ((rg == 2'd0) ? (we ? (tx_full | busy) : rx_empty) :
                         (rg == 2'd1) ? (we & (tx_empty | busy)) : 1'b0);
    assign ch_err[k] = cerr;
    assign act       = sel & ~cerr;
    assign tx_push   = act & we & (rg == 2'd0);
    assign do_send   = act & we & (rg == 2'd1);
    assign rx_pop    = act & ~we & (rg == 2'd0);
    assign ien_wr    = act & we & (rg == 2'd3);
    assign tx_pop    = busy & noc_out_ready[k];
    assign rx_push   = noc_in_valid[k] & noc_in_ready[k];
    assign pend_inc  = rx_push & noc_in_last[k];
    assign pend_dec  = rx_pop & head_last;

    assign noc_in_ready[k]         = rdy_en & ~rx_full;
    assign noc_out_valid[k]        = busy;
    assign noc_out_last[k]         = busy & (tx_lvl == LW'(1));
    assign noc_out_flit[k*W +: W]  = busy ? tx_mem[tx_rp] : '0;
    assign ch_irq[k]               = ien & (pend != 8'd0);

    always_comb begin
      rd = '0;
      case (rg)
        2'd0:    rd = 32'(rx_head[W-1:0]);
        2'd1:    rd = {16'(tx_lvl), 15'b0, busy};
        2'd2:    rd = {16'(rx_lvl), pend, 6'b0, head_last, ~rx_empty};
        default: rd = {31'b0, ien};
      endcase
    end
    assign ch_rdata[k] = sel ? rd : '0;

    always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= wb_dat_i[W-1:0];
      if (rx_push) rx_mem[rx_wp] <= {noc_in_last[k], noc_in_flit[k*W +: W]};
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tx_state <= IDLE;
        tx_wp    <= '0;
        tx_rp    <= '0;
        rx_wp    <= '0;
        rx_rp    <= '0;
        tx_lvl   <= '0;
        rx_lvl   <= '0;
        pend     <= '0;
        ien      <= 1'b0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + AW'(1);
        if (tx_pop)  tx_rp <= tx_rp + AW'(1);
        tx_lvl <= tx_lvl + LW'(tx_push) - LW'(tx_pop);
        case (tx_state)
          IDLE:    if (do_send) tx_state <= SEND;
          default: if (tx_pop && tx_lvl == LW'(1)) tx_state <= IDLE;
        endcase
        if (rx_push) rx_wp <= rx_wp + AW'(1);
        if (rx_pop)  rx_rp <= rx_rp + AW'(1);
        rx_lvl <= rx_lvl + LW'(rx_push) - LW'(rx_pop);
        if (pend_inc && !pend_dec && pend != 8'hFF)
          pend <= pend + 8'd1;
        else if (pend_dec && !pend_inc && pend != 8'd0)
          pend <= pend - 8'd1;
        if (ien_wr) ien <= wb_dat_i[0];
      end
    end
  end
endmodule

// File: tb/tb_mpi_wb_mc.sv
// tb/tb_mpi_wb_mc.sv - Self-checking bench for mpi_wb_mc
// Directed plan steps plus randomized RX traffic checked against a queue-based model.
module tb_mpi_wb_mc;
  localparam int W = 32, SIZE = 16, N = 2;

  logic             clk = 1'b0, rst = 1'b0;
  logic [N*W-1:0]   noc_out_flit, noc_in_flit;
  logic [N-1:0]     noc_out_last, noc_out_valid, noc_out_ready;
  logic [N-1:0]     noc_in_last, noc_in_valid, noc_in_ready;
  logic [31:0]      wb_adr_i, wb_dat_i, wb_dat_o;
  logic             wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o, irq;

  int               tests = 0, fails = 0;
  logic [32:0]      rxq [N][$];
  logic [31:0]      txq [$];
  int               pend [N];
  logic             ien_m [N];

  mpi_wb_mc #(.NOC_FLIT_WIDTH(W), .SIZE(SIZE), .N(N)) dut (
    .clk(clk), .rst(rst),
    .noc_out_flit(noc_out_flit), .noc_out_last(noc_out_last),
    .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready),
    .noc_in_flit(noc_in_flit), .noc_in_last(noc_in_last),
    .noc_in_valid(noc_in_valid), .noc_in_ready(noc_in_ready),
    .wb_adr_i(wb_adr_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] adr(input int ch, input int r);
    return 32'(ch * 16 + r * 4);
  endfunction

  function automatic logic [31:0] rxstat_exp(input int ch);
    logic hl;
    logic ne;
    ne = (rxq[ch].size() != 0);
    hl = ne ? rxq[ch][0][32] : 1'b0;
    return {16'(rxq[ch].size()), 8'(pend[ch]), 6'b0, hl, ne};
  endfunction

  function automatic logic irq_exp();
    logic r;
    r = 1'b0;
    for (int c = 0; c < N; c++) r = r | (ien_m[c] & (pend[c] != 0));
    return r;
  endfunction

  // One idle cycle, then a single-cycle request; the response is sampled one edge later.
  task automatic wb(input logic [31:0] a, input logic w, input logic [31:0] d,
                    output logic [31:0] rd, output logic ack, output logic err);
    @(posedge clk); #1;
    wb_adr_i = a; wb_we_i = w; wb_dat_i = d; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    rd = wb_dat_o; ack = wb_ack_o; err = wb_err_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d, input logic exp_err,
                    input string tag);
    logic [31:0] rd;
    logic ack, err;
    wb(adr(ch, r), 1'b1, d, rd, ack, err);
    chk(tag, {30'b0, ack, err}, exp_err ? 32'd1 : 32'd2);
  endtask

  task automatic rd_reg(input int ch, input int r, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    logic ack, err;
    wb(adr(ch, r), 1'b0, 32'h0, rd, ack, err);
    chk({tag, "_ack"}, {30'b0, ack, err}, 32'd2);
    chk(tag, rd, exp);
  endtask

  task automatic rd_data(input int ch, input string tag);
    logic [31:0] rd;
    logic ack, err;
    logic [32:0] e;
    wb(adr(ch, 0), 1'b0, 32'h0, rd, ack, err);
    if (rxq[ch].size() == 0) begin
      chk({tag, "_err"}, {30'b0, ack, err}, 32'd1);
    end else begin
      e = rxq[ch].pop_front();
      chk({tag, "_ack"}, {30'b0, ack, err}, 32'd2);
      chk(tag, rd, e[31:0]);
      if (e[32] && pend[ch] > 0) pend[ch]--;
    end
  endtask

  task automatic inject(input int ch, input logic [31:0] f, input logic l);
    int n;
    n = 0;
    noc_in_valid[ch] = 1'b1; noc_in_flit[ch*W +: W] = f; noc_in_last[ch] = l;
    while (!noc_in_ready[ch] && n < 50) begin @(posedge clk); #1; n++; end
    chk("inject_ready", 32'(noc_in_ready[ch]), 32'd1);
    @(posedge clk); #1;
    noc_in_valid[ch] = 1'b0; noc_in_last[ch] = 1'b0;
    rxq[ch].push_back({l, f});
    if (l && pend[ch] < 255) pend[ch]++;
  endtask

  task automatic tx_fill(input int ch, input int cnt, input logic [31:0] base);
    for (int i = 0; i < cnt; i++) begin
      wr(ch, 0, base + 32'(i), 1'b0, "tx_push");
      txq.push_back(base + 32'(i));
    end
  endtask

  task automatic tx_drain(input int ch, input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    noc_out_ready[ch] = 1'b1;
    while (txq.size() != 0 && n < 100) begin
      @(negedge clk); n++;
      chk({tag, "_other_idle"}, 32'(noc_out_valid[1-ch]), 32'd0);
      if (noc_out_valid[ch]) begin
        e = txq.pop_front();
        chk({tag, "_flit"}, noc_out_flit[ch*W +: W], e);
        chk({tag, "_last"}, 32'(noc_out_last[ch]), 32'(txq.size() == 0));
      end
    end
    chk({tag, "_remaining"}, 32'(txq.size()), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, 32'(noc_out_valid[ch]), 32'd0);
    noc_out_ready[ch] = 1'b0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin rxq[c].delete(); pend[c] = 0; ien_m[c] = 1'b0; end
    txq.delete();
  endtask

  initial begin
    logic [31:0] rd, f;
    logic ack, err;
    int ch, act;

    noc_out_ready = '0; noc_in_flit = '0; noc_in_last = '0; noc_in_valid = '0;
    wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    model_reset();

    // 1: reset state and post-release readiness
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(noc_in_ready), 32'd0);
    chk("rst_out_valid", 32'(noc_out_valid), 32'd0);
    chk("rst_wb", {29'b0, wb_ack_o, wb_err_o, irq}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    @(negedge clk); rst = 1'b1;
    #1 chk("release_in_ready_before_edge", 32'(noc_in_ready), 32'd0);
    @(posedge clk); #1;
    chk("release_in_ready", 32'(noc_in_ready), 32'd3);
    rd_reg(0, 3, 32'd0, "ctrl_rst");
    rd_reg(0, 2, 32'd0, "rxstat_rst");
    rd_reg(0, 1, 32'd0, "txstat_rst");

    // 2: ch1 3-flit packet with a stalled receiver
    tx_fill(1, 3, 32'hA1);
    wr(1, 1, 32'h0, 1'b0, "send1");
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(noc_out_valid[1]), 32'd1);
      chk("stall_flit", noc_out_flit[W +: W], 32'hA1);
      chk("stall_last", 32'(noc_out_last[1]), 32'd0);
      chk("stall_lane0", 32'(noc_out_valid[0]), 32'd0);
      @(posedge clk); #1;
    end
    tx_drain(1, "tx1");
    rd_reg(1, 1, 32'd0, "txstat1_done");

    // 3: ch0 two-flit packet with interrupt
    wr(0, 3, 32'd1, 1'b0, "ien0_set");
    ien_m[0] = 1'b1;
    inject(0, 32'h11, 1'b0);
    inject(0, 32'h22, 1'b1);
    @(posedge clk); #1;
    chk("irq_set", 32'(irq), 32'd1);
    rd_reg(0, 2, 32'h0002_0101, "rxstat_pkt");
    rd_data(0, "rx_11");
    rd_data(0, "rx_22");
    chk("irq_hold", 32'(irq), 32'd1);
    @(posedge clk); #1;
    chk("irq_fall", 32'(irq), 32'd0);

    // 4: fill ch0 RX, back-pressure, drain
    for (int i = 0; i < SIZE; i++) inject(0, $urandom, (i % 4) == 3);
    chk("rx_full_ready", 32'(noc_in_ready[0]), 32'd0);
    f = $urandom;
    noc_in_valid[0] = 1'b1; noc_in_flit[0 +: W] = f; noc_in_last[0] = 1'b1;
    @(posedge clk); #1;
    chk("rx_full_hold", 32'(noc_in_ready[0]), 32'd0);
    rd_reg(0, 2, rxstat_exp(0), "rxstat_full");
    rd_data(0, "rx_full_pop");
    chk("rx_ready_back", 32'(noc_in_ready[0]), 32'd1);
    @(posedge clk); #1;
    noc_in_valid[0] = 1'b0; noc_in_last[0] = 1'b0;
    rxq[0].push_back({1'b1, f}); pend[0]++;
    chk("rx_refull", 32'(noc_in_ready[0]), 32'd0);
    rd_reg(0, 2, rxstat_exp(0), "rxstat_17");
    while (rxq[0].size() != 0) rd_data(0, "rx_drain");
    rd_data(0, "rx_drain_empty");

    // random RX traffic on both channels
    for (int it = 0; it < 60; it++) begin
      ch = $urandom_range(0, N-1);
      act = $urandom_range(0, 3);
      case (act)
        0: if (rxq[ch].size() < SIZE) inject(ch, $urandom, 1'($urandom_range(0, 1)));
           else rd_data(ch, "rnd_pop_full");
        1: rd_data(ch, "rnd_pop");
        2: rd_reg(ch, 2, rxstat_exp(ch), "rnd_rxstat");
        default: begin
          f = 32'($urandom_range(0, 1));
          wr(ch, 3, f, 1'b0, "rnd_ctrl_wr");
          ien_m[ch] = f[0];
          rd_reg(ch, 3, 32'(ien_m[ch]), "rnd_ctrl_rd");
        end
      endcase
      @(posedge clk); #1;
      chk("rnd_irq", 32'(irq), 32'(irq_exp()));
    end

    // 5: error cases
    while (rxq[1].size() != 0) rd_data(1, "pre5_drain");
    wb(adr(2, 0), 1'b0, 32'h0, rd, ack, err);
    chk("err_ch2_rd", {30'b0, ack, err}, 32'd1);
    chk("err_ch2_dat", rd, 32'd0);
    wr(2, 3, 32'd1, 1'b1, "err_ch2_wr");
    rd_reg(0, 3, 32'(ien_m[0]), "ctrl0_unchanged");
    rd_data(1, "err_rx_empty");
    rd_reg(1, 2, 32'd0, "rxstat1_unchanged");
    wr(1, 1, 32'h0, 1'b1, "err_send_empty");
    rd_reg(1, 1, 32'd0, "txstat1_unchanged");
    tx_fill(0, SIZE, 32'h100);
    wr(0, 0, 32'hDEAD, 1'b1, "err_tx_full");
    rd_reg(0, 1, 32'h0010_0000, "txstat_full");
    wr(0, 1, 32'h0, 1'b0, "send0");
    wr(0, 0, 32'hBEEF, 1'b1, "err_tx_busy");
    wr(0, 1, 32'h0, 1'b1, "err_send_busy");
    rd_reg(0, 1, 32'h0010_0001, "txstat_busy");
    tx_drain(0, "tx0");
    rd_reg(0, 1, 32'd0, "txstat0_done");

    // 6: reset during transmission
    tx_fill(1, 4, 32'hB0);
    wr(1, 1, 32'h0, 1'b0, "send1b");
    chk("pre_rst_valid", 32'(noc_out_valid[1]), 32'd1);
    noc_out_ready[1] = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_async_valid", 32'(noc_out_valid), 32'd0);
    chk("rst_async_ready", 32'(noc_in_ready), 32'd0);
    noc_out_ready = '0;
    model_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rerelease_ready", 32'(noc_in_ready), 32'd3);
    rd_reg(1, 1, 32'd0, "txstat_after_rst");
    wr(1, 1, 32'h0, 1'b1, "err_send_after_rst");
    rd_reg(0, 3, 32'd0, "ctrl_after_rst");
    rd_reg(0, 2, 32'd0, "rxstat_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
